// File: rtl/nspi_pkg.sv
// Shared definitions for the nspi transmitter/receiver pair: SPI mode, synchroniser
// depth, receiver FSM states and the bit-position helper used by both directions.
package nspi_pkg;

    typedef enum logic [0:0] {
        MODE0 = 1'b0
    } spi_mode_e;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_e;

    localparam int NSPI_SYNC_STAGES = 2;

    // Word bit that carries serial position 'pos' (0 = first bit on the wire).
    function automatic int nspi_bit_index(input int pos, input int size, input bit msb_first);
        return msb_first ? (size - 1 - pos) : pos;
    endfunction

endpackage

// File: rtl/nspi_sync.sv
// Multi-bit flop-chain synchroniser; each bit is synchronised independently, so a
// multi-bit input is only safe when the bits are sampled under an external strobe.
module nspi_sync
    import nspi_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_stage [NSPI_SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSPI_SYNC_STAGES; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_async;
            for (int i = 1; i < NSPI_SYNC_STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_sync = r_stage[NSPI_SYNC_STAGES-1];

endmodule

// File: rtl/nspi_rx.sv
// Multi-lane SPI mode-0 receiver: oversampled spi_clk, bit-count framing, one word per lane.
// Optional idle-timeout abort of partial frames is enabled by defining NSPI_RX_TIMEOUT_EN.
module nspi_rx
    import nspi_pkg::*;
#(
    parameter int CHANNEL_NUMBER = 2,
    parameter int SPI_SIZE       = 8,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_clk,
    input  logic [CHANNEL_NUMBER-1:0] spi_mosi,
    output logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER],
    output logic                      rx_valid,
    output logic                      rx_busy,
    output logic                      rx_abort
);

    localparam int                CNT_W    = (SPI_SIZE > 1) ? $clog2(SPI_SIZE) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(SPI_SIZE - 1);

    logic                      w_clk_s2;
    logic                      r_clk_s3;
    logic                      w_rise;
    logic [CHANNEL_NUMBER-1:0] w_mosi_s2;
    logic [CNT_W-1:0]          r_bit_cnt;
    rx_state_e                 r_state;
    rx_state_e                 w_state_next;
    logic                      w_complete;
    logic                      w_abort;
    logic                      r_valid;
    logic [SPI_SIZE-1:0]       w_word_next [CHANNEL_NUMBER];

    nspi_sync #(.WIDTH(1)) u_sync_clk (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_clk),
        .o_sync  (w_clk_s2)
    );

    nspi_sync #(.WIDTH(CHANNEL_NUMBER)) u_sync_mosi (
        .clk     (clk),
        .rst     (rst),
        .i_async (spi_mosi),
        .o_sync  (w_mosi_s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_s3 <= 1'b0;
        end else begin
            r_clk_s3 <= w_clk_s2;
        end
    end

    assign w_rise = w_clk_s2 & ~r_clk_s3;

`ifdef NSPI_RX_TIMEOUT_EN
    localparam int               IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] r_idle_cnt;
    logic              r_abort;

    assign w_abort = (r_state == RX_SHIFT) && !w_rise && (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge clk) begin
        if (rst || (r_state != RX_SHIFT) || w_rise) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != IDLE_LAST) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_abort <= 1'b0;
        end else begin
            r_abort <= w_abort;
        end
    end

    assign rx_abort = r_abort;
`else
    assign w_abort  = 1'b0;
    assign rx_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (w_rise) begin
                    w_state_next = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (w_rise && (r_bit_cnt == LAST_BIT)) begin
                    w_complete   = 1'b1;
                    w_state_next = RX_IDLE;
                end else if (w_abort) begin
                    w_state_next = RX_IDLE;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_abort) begin
            r_bit_cnt <= '0;
        end else if (w_rise) begin
            r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
        end
    end

    // The final bit goes straight into data_out, so each lane stores only SPI_SIZE-1 bits.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNEL_NUMBER; gi++) begin : g_lane
            logic [SPI_SIZE-2:0] r_shift;
            logic [SPI_SIZE-2:0] w_shift_next;

            if (MSB_FIRST != 0) begin : g_msb
                assign w_word_next[gi] = {r_shift, w_mosi_s2[gi]};
                assign w_shift_next    = w_word_next[gi][SPI_SIZE-2:0];
            end else begin : g_lsb
                assign w_word_next[gi] = {w_mosi_s2[gi], r_shift};
                assign w_shift_next    = w_word_next[gi][SPI_SIZE-1:1];
            end

            always_ff @(posedge clk) begin
                if (rst || w_abort) begin
                    r_shift <= '0;
                end else if (w_rise) begin
                    r_shift <= w_shift_next;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                data_out[c] <= '0;
            end
            r_valid <= 1'b0;
        end else begin
            if (w_complete) begin
                for (int c = 0; c < CHANNEL_NUMBER; c++) begin
                    data_out[c] <= w_word_next[c];
                end
            end
            r_valid <= w_complete;
        end
    end

    assign rx_valid = r_valid;
    assign rx_busy  = (r_state == RX_SHIFT);

endmodule

// File: tb/tb_nspi_rx.sv
// Bench for nspi_rx: an MSB-first and an LSB-first receiver share one bit-banged bus and are
// compared every cycle against a frame-level model that counts rises and packs words arithmetically.
module tb_nspi_rx;

    localparam int CH  = 2;
    localparam int SZ  = 8;
    localparam int TMO = 64;
    localparam int LAT = 3;

    logic          clk;
    logic          rst;
    logic          spi_clk;
    logic [CH-1:0] spi_mosi;
    logic [SZ-1:0] data_a [CH];
    logic [SZ-1:0] data_b [CH];
    logic          valid_a, busy_a, abort_a;
    logic          valid_b, busy_b, abort_b;

    nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .data_out (data_a),
        .rx_valid (valid_a),
        .rx_busy  (busy_a),
        .rx_abort (abort_a)
    );

    nspi_rx #(.CHANNEL_NUMBER(CH), .SPI_SIZE(SZ), .MSB_FIRST(0), .TIMEOUT_CYCLES(TMO)) dut_lsb (
        .clk      (clk),
        .rst      (rst),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .data_out (data_b),
        .rx_valid (valid_b),
        .rx_busy  (busy_b),
        .rx_abort (abort_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit            rise;
        logic [CH-1:0] mosi;
    } ev_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   abort_cnt = 0;
    ev_t  pipe [$];
    bit   prev_clk = 1'b0;

    // Reference model: bits seen so far in the current frame plus the last published words.
    int          nbits = 0;
    int          idle = 0;
    bit          exp_valid = 1'b0;
    bit          exp_abort = 1'b0;
    logic [7:0]  acc_msb [CH];
    logic [7:0]  acc_lsb [CH];
    logic [7:0]  exp_a [CH];
    logic [7:0]  exp_b [CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        nbits = 0;
        idle  = 0;
        for (int c = 0; c < CH; c++) begin
            acc_msb[c] = '0;
            acc_lsb[c] = '0;
            exp_a[c]   = '0;
            exp_b[c]   = '0;
        end
    endtask

    task automatic model_step(input ev_t e);
        if (e.rise) begin
            if (nbits == 0) begin
                for (int c = 0; c < CH; c++) begin
                    acc_msb[c] = '0;
                    acc_lsb[c] = '0;
                end
            end
            for (int c = 0; c < CH; c++) begin
                acc_msb[c] = 8'((acc_msb[c] * 2) + e.mosi[c]);
                acc_lsb[c] = 8'(acc_lsb[c] + (e.mosi[c] << nbits));
            end
            nbits++;
            idle = 0;
            if (nbits == SZ) begin
                for (int c = 0; c < CH; c++) begin
                    exp_a[c] = acc_msb[c];
                    exp_b[c] = acc_lsb[c];
                end
                exp_valid = 1'b1;
                nbits = 0;
            end
        end else if (nbits > 0) begin
`ifdef NSPI_RX_TIMEOUT_EN
            idle++;
            if (idle == TMO) begin
                exp_abort = 1'b1;
                nbits = 0;
            end
`endif
        end
    endtask

    // One clk cycle: log the drive applied before the edge, then check at the falling edge.
    task automatic tick();
        ev_t e;
        e.rise   = spi_clk && !prev_clk;
        e.mosi   = spi_mosi;
        prev_clk = spi_clk;
        if (rst) pipe.delete();
        else     pipe.push_back(e);
        @(negedge clk);
        cyc++;
        exp_valid = 1'b0;
        exp_abort = 1'b0;
        if (rst) begin
            model_reset();
        end else if (pipe.size() == LAT) begin
            model_step(pipe.pop_front());
        end
        chk("valid_a", valid_a, exp_valid);
        chk("valid_b", valid_b, exp_valid);
        chk("busy_a", busy_a, nbits > 0);
        chk("busy_b", busy_b, nbits > 0);
        chk("abort_a", abort_a, exp_abort);
        chk("abort_b", abort_b, exp_abort);
        for (int c = 0; c < CH; c++) begin
            chk("data_msb", data_a[c], exp_a[c]);
            chk("data_lsb", data_b[c], exp_b[c]);
        end
        if (valid_a) begin
            valid_cnt++;
            $display("cycle %0d frame %0d msb-first ch0=%02h ch1=%02h lsb-first ch0=%02h ch1=%02h",
                     cyc, valid_cnt, data_a[0], data_a[1], data_b[0], data_b[1]);
        end
        if (abort_a) begin
            abort_cnt++;
            $display("cycle %0d partial frame aborted", cyc);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) tick();
    endtask

    // Sends the first n bits of w0/w1 (bit 7 first on the wire); spi_clk ends low.
    task automatic send_bits(input logic [7:0] w0, input logic [7:0] w1,
                             input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            spi_mosi = {w1[7-i], w0[7-i]};
            spi_clk  = 1'b1;
            repeat (hi) tick();
            spi_clk  = 1'b0;
            repeat (lo) tick();
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int         v0;
        int         a0;
        int         nframes;
        logic [7:0] r0, r1;

        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = '0;
        model_reset();
        repeat (3) tick();
        chk("reset_data", data_a[0], 8'h00);
        chk("reset_busy", busy_a, 1'b0);
        rst = 1'b0;
        tick();

        // Loopback-style frame: ch0 0x0F, ch1 0xF0.
        v0 = valid_cnt;
        send_bits(8'h0F, 8'hF0, 8, 3, 3);
        idle_cycles(6);
        chk("loop_pulses", valid_cnt - v0, 1);
        chk("loop_ch0", data_a[0], 8'h0F);
        chk("loop_ch1", data_a[1], 8'hF0);

        // Two consecutive frames on ch0; the first word holds until the second completes.
        v0 = valid_cnt;
        send_bits(8'h0F, 8'h00, 8, 2, 2);
        idle_cycles(5);
        chk("hold_first", data_a[0], 8'h0F);
        send_bits(8'hBB, 8'h00, 7, 2, 2);
        chk("hold_mid", data_a[0], 8'h0F);
        send_bits(8'h80, 8'h00, 1, 2, 2);
        idle_cycles(5);
        chk("second_word", data_a[0], 8'hBB);
        chk("two_pulses", valid_cnt - v0, 2);

        // Bitstream 1,0,1,1,0,0,0,0 on ch0.
        send_bits(8'hB0, 8'h00, 8, 2, 3);
        idle_cycles(5);
        chk("lsb_first", data_b[0], 8'h0D);
        chk("msb_first", data_a[0], 8'hB0);

        // Reset after 5 bits discards the partial frame.
        v0 = valid_cnt;
        send_bits(8'h5A, 8'hA5, 5, 2, 2);
        chk("busy_mid", busy_a, 1'b1);
        pulse_rst();
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_data", data_a[0], 8'h00);
        idle_cycles(10);
        chk("rst_no_valid", valid_cnt - v0, 0);
        send_bits(8'h3C, 8'hC3, 8, 2, 2);
        idle_cycles(5);
        chk("after_rst", data_a[0], 8'h3C);

        // Three stray clocks, long idle, then a full 0xA5 frame.
        a0 = abort_cnt;
        send_bits(8'hE0, 8'hE0, 3, 2, 2);
        idle_cycles(100);
        send_bits(8'hA5, 8'h5A, 8, 2, 2);
        idle_cycles(6);
`ifdef NSPI_RX_TIMEOUT_EN
        chk("abort_once", abort_cnt - a0, 1);
        chk("resync_word", data_a[0], 8'hA5);
        chk("resync_idle", busy_a, 1'b0);
`else
        chk("no_abort", abort_cnt - a0, 0);
        chk("misaligned", data_a[0], 8'hF4);
        chk("stuck_busy", busy_a, 1'b1);
`endif
        pulse_rst();
        idle_cycles(3);

        // Minimum 2/2 phases, random 0x00/0xFF patterns, mostly back-to-back.
        v0 = valid_cnt;
        nframes = 24;
        for (int f = 0; f < nframes; f++) begin
            r0 = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            r1 = $urandom_range(0, 1) ? 8'hFF : 8'h00;
            send_bits(r0, r1, 8, 2, 2);
            idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(5);
        chk("min_phase_frames", valid_cnt - v0, nframes);

        // Random data with random phases and gaps.
        v0 = valid_cnt;
        nframes = 16;
        for (int f = 0; f < nframes; f++) begin
            r0 = 8'($urandom);
            r1 = 8'($urandom);
            send_bits(r0, r1, 8, $urandom_range(2, 5), $urandom_range(2, 5));
            idle_cycles($urandom_range(0, 10));
        end
        idle_cycles(5);
        chk("random_frames", valid_cnt - v0, nframes);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
